pep_batch_unpack: RTL

Consumes batch-completion commands from the PE-PBS batch scheduler and expands each one into a serial stream of per-PBS completion notifications. Each notification carries the PBS slot id and its GRAM id. The block sits at the output end of the batch pipe: the scheduler writes whole batches, and this block reads them back out one PBS at a time toward the slot-release logic. Slot ids wrap modulo TOTAL_PBS_NB.

---
 rtl/pep_batch_unpack_pkg.sv | 27 ++
 rtl/pep_batch_unpack_if.sv | 29 ++
 rtl/pep_pid_wrap_cnt.sv | 43 ++++
 rtl/pep_batch_unpack.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pep_batch_unpack_pkg.sv
// Shared widths, types and helpers for the batch unpacker.
package pep_batch_unpack_pkg;

  localparam int unsigned BATCH_PBS_NB = 12;
  localparam int unsigned TOTAL_PBS_NB = 27;
  localparam int unsigned GRAM_NB      = 3;

  localparam int unsigned PID_W  = $clog2(TOTAL_PBS_NB);
  localparam int unsigned GID_W  = $clog2(GRAM_NB);
  localparam int unsigned BPBS_W = $clog2(BATCH_PBS_NB + 1);

  typedef logic [PID_W-1:0]  pid_t;
  typedef logic [GID_W-1:0]  gid_t;
  typedef logic [BPBS_W-1:0] bpbs_t;

  typedef struct packed {
    pid_t pid;
    gid_t gid;
    logic last;
  } done_t;

  // GRAM owning a slot.
  function automatic gid_t pid2gid(pid_t pid);
    return gid_t'(pid % pid_t'(GRAM_NB));
  endfunction

endpackage

// File: rtl/pep_batch_unpack_if.sv
// Command and per-PBS notification bundle of the batch unpacker.
interface pep_batch_unpack_if;
  import pep_batch_unpack_pkg::*;

  logic  cmd_vld;
  logic  cmd_rdy;
  pid_t  cmd_pid;
  bpbs_t cmd_pbs_nb;
  logic  done_vld;
  logic  done_rdy;
  pid_t  done_pid;
  gid_t  done_gid;
  logic  done_last;
  logic  busy;
  logic  cmd_err;

  // Scheduler / slot-release side.
  modport master (
    output cmd_vld, cmd_pid, cmd_pbs_nb, done_rdy,
    input  cmd_rdy, done_vld, done_pid, done_gid, done_last, busy, cmd_err
  );

  // Unpacker side.
  modport slave (
    input  cmd_vld, cmd_pid, cmd_pbs_nb, done_rdy,
    output cmd_rdy, done_vld, done_pid, done_gid, done_last, busy, cmd_err
  );

endinterface

// File: rtl/pep_pid_wrap_cnt.sv
// Loadable incrementing counter wrapping at WrapVal, with a wrap pulse.
module pep_pid_wrap_cnt #(
  parameter int unsigned Width   = 5,
  parameter int unsigned WrapVal = 27
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [Width-1:0] o_cnt,
  output logic             o_wrap
);

  logic [Width-1:0] r_cnt;
  logic [Width-1:0] w_cnt_nxt;

  assign o_wrap = i_inc & (r_cnt == Width'(WrapVal - 1));
  assign o_cnt  = r_cnt;

  // Next value: load beats clear beats increment.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc) begin
      w_cnt_nxt = o_wrap ? '0 : r_cnt + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/pep_batch_unpack.sv
// Expands batch-completion commands into serial per-PBS notifications.
// Optional build macro PEP_BATCH_UNPACK_CHECK_EN: drop malformed commands and
// pulse cmd_err; otherwise every command is run and cmd_err is tied low.
module pep_batch_unpack
  import pep_batch_unpack_pkg::*;
(
  input  logic                     clk,
  input  logic                     a_rst_n,
  pep_batch_unpack_if.slave        bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e r_state;
  state_e w_state_nxt;
  bpbs_t  r_rem;
  bpbs_t  w_rem_nxt;
  logic   r_cmd_rdy;
  logic   w_accept;
  logic   w_hs;
  logic   w_bad;
  logic   w_pid_wrap;
  pid_t   w_pid;
  gid_t   w_gid;

  // cmd_rdy is only ever high in IDLE, so it doubles as the state qualifier.
  assign w_accept = bus.cmd_vld & r_cmd_rdy;
  assign w_hs     = (r_state == StRun) & bus.done_rdy;

`ifdef PEP_BATCH_UNPACK_CHECK_EN
  logic r_cmd_err;

  assign w_bad = (bus.cmd_pbs_nb == '0)
               | (bus.cmd_pbs_nb > bpbs_t'(BATCH_PBS_NB))
               | (bus.cmd_pid >= pid_t'(TOTAL_PBS_NB));

  // One-cycle error pulse after a dropped command.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_accept & w_bad;
    end
  end

  assign bus.cmd_err = r_cmd_err;
`else
  assign w_bad       = 1'b0;
  assign bus.cmd_err = 1'b0;
`endif

  // Next-state and remaining-count logic.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_rem_nxt = bus.cmd_pbs_nb;
          if (!w_bad) begin
            w_state_nxt = StRun;
          end
        end
      end
      StRun: begin
        if (w_hs) begin
          w_rem_nxt = r_rem - bpbs_t'(1);
          if (r_rem == bpbs_t'(1)) begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, remaining count and registered command ready.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_state   <= StIdle;
      r_rem     <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_cmd_rdy <= (w_state_nxt == StIdle);
    end
  end

  pep_pid_wrap_cnt #(
    .Width   (PID_W),
    .WrapVal (TOTAL_PBS_NB)
  ) u_pid_cnt (
    .clk        (clk),
    .a_rst_n    (a_rst_n),
    .i_load     (w_accept),
    .i_load_val (bus.cmd_pid),
    .i_clr      (1'b0),
    .i_inc      (w_hs),
    .o_cnt      (w_pid),
    .o_wrap     (w_pid_wrap)
  );

  // Cleared on pid wrap so gid stays pid mod GRAM_NB for any slot count.
  pep_pid_wrap_cnt #(
    .Width   (GID_W),
    .WrapVal (GRAM_NB)
  ) u_gid_cnt (
    .clk        (clk),
    .a_rst_n    (a_rst_n),
    .i_load     (w_accept),
    .i_load_val (pid2gid(bus.cmd_pid)),
    .i_clr      (w_pid_wrap),
    .i_inc      (w_hs),
    .o_cnt      (w_gid),
    .o_wrap     ()
  );

  assign bus.cmd_rdy   = r_cmd_rdy;
  assign bus.done_vld  = (r_state == StRun);
  assign bus.busy      = (r_state == StRun);
  assign bus.done_pid  = w_pid;
  assign bus.done_gid  = w_gid;
  assign bus.done_last = (r_state == StRun) & (r_rem == bpbs_t'(1));

endmodule
